// File: rtl/uart_rx_8n1_pkg.sv
// Shared UART definitions: receiver state encoding and
// bit-period helper used by the 8N1 receiver.
package uart_defs;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    function automatic int cycles_per_bit(input int clock_hz, input int baud);
        return clock_hz / baud;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous inputs with a
// selectable reset value (idle level of the line).
module sync_2ff #(
    parameter int               WIDTH       = 1,
    parameter logic [WIDTH-1:0] RESET_VALUE = '1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    // Two back-to-back flops give metastability time to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta <= RESET_VALUE;
            q    <= RESET_VALUE;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/uart_rx_8n1.sv
// 8N1 UART receiver: mid-bit sampling, one-cycle byte strobe
// and one-cycle framing-error strobe.
module uart_rx_8n1
    import uart_defs::*;
#(
    parameter int CLOCK_HZ = 25_000_000,
    parameter int BAUD     = 115_200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_error
);

    localparam int CPB  = cycles_per_bit(CLOCK_HZ, BAUD);
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB);

    localparam logic [CW-1:0] CNT_BIT  = CW'(CPB - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(HALF - 1);

    logic          rx_s;
    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shreg, shreg_n;
    logic [7:0]    data_n;
    logic          valid_n, ferr_n;

    sync_2ff #(
        .WIDTH       (1),
        .RESET_VALUE (1'b1)
    ) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (rx),
        .q   (rx_s)
    );

    // State, counters, shift register and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            data        <= '0;
            valid       <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            data        <= data_n;
            valid       <= valid_n;
            frame_error <= ferr_n;
        end
    end

    // Next-state logic: counter restarts whenever a state is (re)entered.
    always_comb begin
        state_n = state;
        cnt_n   = cnt + 1'b1;
        idx_n   = idx;
        shreg_n = shreg;
        data_n  = data;
        valid_n = 1'b0;
        ferr_n  = 1'b0;
        unique case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) begin
                    state_n = START;
                end
            end
            START: begin
                if (cnt == CNT_HALF) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == CNT_BIT) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[7:1]};
                    idx_n   = idx + 3'd1;
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end
                end
            end
            STOP: begin
                if (cnt == CNT_BIT) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        data_n  = shreg;
                        valid_n = 1'b1;
                        state_n = IDLE;
                    end else begin
                        ferr_n  = 1'b1;
                        state_n = WAIT_HIGH;
                    end
                end
            end
            WAIT_HIGH: begin
                cnt_n = '0;
                if (rx_s) begin
                    state_n = IDLE;
                end
            end
            default: begin
                cnt_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

endmodule
